mem_sp_strb: RTL and testbench
==============================

# mem_sp_strb

Parametrised single-port synchronous memory for the AXI4-Lite slave datapath. It adds per-byte write strobes, a selectable 1- or 2-cycle read latency with a `rd_valid` qualifier, and a `req`/`ready` handshake. An optional hardware clear sequencer zeroes the whole array after reset, so contents no longer depend on a preload file. It sits between the AXI4-Lite slave FSM and storage, and mirrors WSTRB semantics directly.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: word address width; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 32: word width; must be a multiple of 8.
- `RD_LATENCY`, default 1: accept-to-`rd_valid` latency; legal values are 1 and 2.
- `CLEAR_ON_RESET`, default 1: when 1, every word is zeroed after reset before `ready` asserts.

Ports:
- `CLK`  in  1  clock; all logic rising-edge.
- `RSTn`  in  1  reset; asynchronous, active-low.
- `req`  in  1  access request.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  ADDR_WIDTH  word address.
- `wr_data`  in  DATA_WIDTH  write data.
- `wr_strb`  in  DATA_WIDTH/8  byte-lane enables; bit i covers `wr_data[8i+7:8i]`.
- `ready`  out  1  block accepts a request this cycle.
- `rd_data`  out  DATA_WIDTH  read data; holds its last value between reads.
- `rd_valid`  out  1  one-cycle pulse marking new `rd_data`.
- `init_done`  out  1  clear sequence complete; stays high until the next reset.

## Operation
- **Reset outputs:** `rd_data`=0, `rd_valid`=0, `ready`=0, `init_done`=0. All pipeline registers, the FSM and the clear counter reset. Array contents are not reset asynchronously.
- **FSM states:** `CLEAR`, `RUN`.
  - Reset state is `CLEAR` if `CLEAR_ON_RESET`=1, otherwise `RUN` with `ready` asserting after the first edge.
- **CLEAR:**
  - A counter starting at 0 writes all-zero to `mem[counter]`, one word per edge.
  - On the edge that writes address 2**ADDR_WIDTH-1, the FSM moves to `RUN` and `ready`/`init_done` are set to 1.
  - The counter does not wrap.
  - `req` is ignored in this state: not queued and no `rd_valid`.
- **RUN:** `ready`=1 permanently. A transaction is accepted on any edge where `req && ready`.
- **Write** (`we`=1):
  - Only lanes with their strobe bit set are updated; other lanes keep their old value.
  - `wr_strb`=0 is accepted and changes nothing.
  - A write never produces `rd_valid` and never changes `rd_data`.
- **Read** (`we`=0):
  - Returns `mem[addr]` as it stands after all earlier accepted writes.
  - A write on edge k followed by a read of the same address on edge k+1 returns the new data.
- **Ordering:** one access per cycle, either read or write, never both. Back-to-back reads at full rate are required with either latency.
- **Reset during CLEAR or RUN:** all outputs return to reset values immediately. In-flight reads are discarded (no `rd_valid`). `CLEAR` restarts from address 0.

## Timing
- **Clear duration:** with `CLEAR_ON_RESET`=1, `ready` and `init_done` rise after the 2**ADDR_WIDTH-th rising edge following RSTn deassertion (64 edges at the defaults).
- **Read latency:** for a read accepted on edge k, `rd_valid`=1 and `rd_data` are updated after edge k+`RD_LATENCY`.
  - `rd_valid` is high for exactly one cycle per accepted read.
  - `rd_data` holds until the next read returns.
- **RD_LATENCY=2:** adds one output register stage. A read accepted on edge k, followed by a write on edge k+1 to the same address, returns the pre-write data.
- **Write latency:** the write takes effect at edge k; no output response.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset and clear:** reset, release; hold `req`=1, `we`=0 throughout → `ready`/`init_done` go high after edge 64; no `rd_valid` before that; first read of addr 0x3F returns 0x00000000.
- **Strobed writes:** write 0xAABBCCDD with strb 0xF to 0x05, then 0x11223344 with strb 0x5 to 0x05, then read → `rd_data`=0xAA22CC44 with `rd_valid` at edge+1 (`RD_LATENCY`=1) and edge+2 (`RD_LATENCY`=2).
- **Streaming reads:** write addr i = i*0x01010101 for i=0..63; then 64 consecutive reads of addresses 0..63 → 64 consecutive `rd_valid` pulses with matching data, no bubbles.
- **Write-then-read and empty strobe:** write 0xDEADBEEF to 0x3F, read 0x3F next cycle → 0xDEADBEEF. A write with `wr_strb`=0 leaves the word unchanged, and `rd_data` stays stable through the writes.
- **Reset mid-clear:** assert RSTn low at edge 30 of `CLEAR`, release → `ready` rises after edge 64 counted from the new release; addresses written before the reset read 0.
- **Reset with read in flight:** `RD_LATENCY`=2, accept a read, assert reset the next cycle → no `rd_valid`, `rd_data`=0.

Source files
------------

// File: rtl/mem_sp_strb.sv
// mem_sp_strb
// Single-port synchronous word memory with per-byte write strobes, a
// req/ready handshake and a 1- or 2-cycle read latency qualified by rd_valid.
// When CLEAR_ON_RESET is set, a clear sequencer zeroes every word after reset
// before the block starts accepting requests.
//
// Parameters:
//   ADDR_WIDTH      word address width, depth = 2**ADDR_WIDTH
//   DATA_WIDTH      word width, multiple of 8
//   RD_LATENCY      accept-to-rd_valid latency, 1 or 2
//   CLEAR_ON_RESET  1 = zero the array after reset before ready asserts
//
// Ports:
//   CLK        in   clock, rising edge
//   RSTn       in   asynchronous active-low reset
//   req        in   access request
//   we         in   1 = write, 0 = read (sampled with req)
//   addr       in   word address
//   wr_data    in   write data
//   wr_strb    in   byte-lane write enables
//   ready      out  request accepted on this edge when req is high
//   rd_data    out  read data, held between reads
//   rd_valid   out  one-cycle pulse marking new rd_data
//   init_done  out  clear sequence complete
module mem_sp_strb #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_done
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    rd_req_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;

  // ready is only ever high in RUN, so it alone qualifies acceptance.
  assign accept = req && ready;

  // Clear sequencer / mode FSM. The clear counter parks on the last address
  // rather than wrapping; ready and init_done rise on the same edge that
  // writes the last word.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= RESET_STATE;
      clr_addr  <= '0;
      ready     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_addr == '1) begin
            state     <= RUN;
            ready     <= 1'b1;
            init_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + ADDR_WIDTH'(1);
          end
        end
        RUN: begin
          ready     <= 1'b1;
          init_done <= 1'b1;
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

  // Storage. Not reset; the clear sequencer owns the write port while in
  // CLEAR and requests are shut out by ready during that time.
  always_ff @(posedge CLK) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (accept && we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_strb[i]) begin
          mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read request stage: the array is read one edge after acceptance, so a
  // write accepted on the acceptance edge of the read can never collide and
  // a write accepted just before the read is already visible.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      rd_req_q <= accept && !we;
      if (accept && !we) begin
        rd_addr_q <= addr;
      end
    end
  end

  // The 2-cycle variant samples the array into an extra stage on the edge
  // after acceptance, so a write on that same edge is not seen by the read.
  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= rd_req_q;
          if (rd_req_q) begin
            s2_data <= mem[rd_addr_q];
          end
        end
      end

      assign out_valid = s2_valid;
      assign out_data  = s2_data;
    end else begin : g_lat1
      assign out_valid = rd_req_q;
      assign out_data  = mem[rd_addr_q];
    end
  endgenerate

  // Registered outputs; rd_data only moves when a read returns.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= out_valid;
      if (out_valid) begin
        rd_data <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_sp_strb.sv
// tb_mem_sp_strb
// Drives two copies of mem_sp_strb (RD_LATENCY 1 and 2) with identical
// stimulus and compares them against a behavioural model: a word array plus
// queues of pending read returns stamped with the cycle they are due.
module tb_mem_sp_strb;

  logic        CLK;
  logic        RSTn;
  logic        req;
  logic        we;
  logic [5:0]  addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  logic        ready1, ready2;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2;
  logic        init_done1, init_done2;

  mem_sp_strb #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .req(req), .we(we), .addr(addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .ready(ready1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .init_done(init_done1)
  );

  mem_sp_strb #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) dut2 (
    .CLK(CLK), .RSTn(RSTn), .req(req), .we(we), .addr(addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .ready(ready2), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .init_done(init_done2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  logic [31:0] model [64];
  rd_t         q1[$];
  rd_t         q2[$];
  int          cyc;
  int          edges;
  bit          exp_ready;
  bit          exp_v1, exp_v2;
  logic [31:0] exp_d1, exp_d2;
  int          n_chk;
  int          n_fail;

  task automatic set_in(input logic r, input logic w, input logic [5:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    req = r; we = w; addr = a; wr_data = d; wr_strb = s;
  endtask

  // One clock edge: apply the memory rules to the model, then sample #1 later.
  task automatic step();
    bit          acc;
    bit          w;
    logic [5:0]  a;
    logic [31:0] d, mask;
    logic [3:0]  s;
    rd_t         e;
    acc = req && exp_ready;
    w = we; a = addr; d = wr_data; s = wr_strb;
    @(posedge CLK);
    cyc++;
    if (acc && w) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      model[a] = (model[a] & ~mask) | (d & mask);
    end else if (acc) begin
      e.d = model[a];
      e.due = cyc + 1; q1.push_back(e);
      e.due = cyc + 2; q2.push_back(e);
    end
    edges++;
    if (!exp_ready && edges == 64) begin
      exp_ready = 1'b1;
      foreach (model[i]) model[i] = 32'h0;
    end
    exp_v1 = 1'b0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      exp_v1 = 1'b1; exp_d1 = q1[0].d; void'(q1.pop_front());
    end
    exp_v2 = 1'b0;
    if (q2.size() > 0 && q2[0].due == cyc) begin
      exp_v2 = 1'b1; exp_d2 = q2[0].d; void'(q2.pop_front());
    end
    #1;
  endtask

  task automatic assert_reset();
    RSTn = 1'b0;
    q1.delete(); q2.delete();
    exp_v1 = 1'b0; exp_v2 = 1'b0; exp_d1 = 32'h0; exp_d2 = 32'h0;
    exp_ready = 1'b0; edges = 0;
    #1;
  endtask

  task automatic release_reset(input int hold);
    repeat (hold) @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    int pulses;
    RSTn = 1'b1;
    set_in(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
    #2;
    assert_reset();
    n_chk++; if (ready1 !== 1'b0 || ready2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got=%b/%b exp=0", ready1, ready2); end
    n_chk++; if (init_done1 !== 1'b0 || init_done2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_init_done got=%b/%b exp=0", init_done1, init_done2); end
    n_chk++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_valid got=%b/%b exp=0", rd_valid1, rd_valid2); end
    n_chk++; if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rd_data got=%h/%h exp=0", rd_data1, rd_data2); end
    set_in(1'b1, 1'b0, 6'h3F, 32'h0, 4'h0);
    release_reset(2);
    for (int i = 0; i < 64; i++) begin
      step();
      n_chk++; if (ready1 !== exp_ready || ready2 !== exp_ready) begin n_fail++; $display("[TB] FAIL clear_ready edge=%0d got=%b/%b exp=%b", edges, ready1, ready2, exp_ready); end
      n_chk++; if (init_done1 !== exp_ready || init_done2 !== exp_ready) begin n_fail++; $display("[TB] FAIL clear_init_done edge=%0d got=%b/%b exp=%b", edges, init_done1, init_done2, exp_ready); end
      n_chk++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_rd_valid edge=%0d got=%b/%b exp=0", edges, rd_valid1, rd_valid2); end
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      set_in(1'b0, 1'b0, 6'h3F, 32'h0, 4'h0);
      if (rd_valid1) pulses++;
      n_chk++; if (rd_valid1 !== exp_v1 || rd_valid2 !== exp_v2) begin n_fail++; $display("[TB] FAIL first_read_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, rd_valid1, rd_valid2, exp_v1, exp_v2); end
      n_chk++; if (rd_data1 !== exp_d1 || rd_data2 !== exp_d2) begin n_fail++; $display("[TB] FAIL first_read_data cyc=%0d got=%h/%h exp=%h/%h", cyc, rd_data1, rd_data2, exp_d1, exp_d2); end
    end
    n_chk++; if (pulses !== 1) begin n_fail++; $display("[TB] FAIL first_read_pulses got=%0d exp=1", pulses); end
    n_chk++; if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin n_fail++; $display("[TB] FAIL first_read_zero got=%h/%h exp=0", rd_data1, rd_data2); end
  endtask

  task automatic test_strobe();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: set_in(1'b1, 1'b1, 6'h05, 32'hAABBCCDD, 4'hF);
        1: set_in(1'b1, 1'b1, 6'h05, 32'h11223344, 4'h5);
        2: set_in(1'b1, 1'b0, 6'h05, 32'h0, 4'h0);
        default: set_in(1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
      endcase
      step();
      n_chk++; if (rd_valid1 !== exp_v1 || rd_valid2 !== exp_v2) begin n_fail++; $display("[TB] FAIL strobe_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, rd_valid1, rd_valid2, exp_v1, exp_v2); end
      n_chk++; if (rd_data1 !== exp_d1 || rd_data2 !== exp_d2) begin n_fail++; $display("[TB] FAIL strobe_data cyc=%0d got=%h/%h exp=%h/%h", cyc, rd_data1, rd_data2, exp_d1, exp_d2); end
      if (i == 3) begin
        n_chk++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hAA22CC44) begin n_fail++; $display("[TB] FAIL strobe_l1_result got=%b/%h exp=1/aa22cc44", rd_valid1, rd_data1); end
      end
      if (i == 4) begin
        n_chk++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'hAA22CC44) begin n_fail++; $display("[TB] FAIL strobe_l2_result got=%b/%h exp=1/aa22cc44", rd_valid2, rd_data2); end
      end
    end
  endtask

  task automatic test_stream();
    int cnt1, cnt2;
    cnt1 = 0; cnt2 = 0;
    for (int i = 0; i < 64 + 64 + 3; i++) begin
      if (i < 64)       set_in(1'b1, 1'b1, 6'(i), i * 32'h01010101, 4'hF);
      else if (i < 128) set_in(1'b1, 1'b0, 6'(i - 64), 32'h0, 4'h0);
      else              set_in(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
      step();
      n_chk++; if (rd_valid1 !== exp_v1 || rd_valid2 !== exp_v2) begin n_fail++; $display("[TB] FAIL stream_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, rd_valid1, rd_valid2, exp_v1, exp_v2); end
      n_chk++; if (rd_data1 !== exp_d1 || rd_data2 !== exp_d2) begin n_fail++; $display("[TB] FAIL stream_data cyc=%0d got=%h/%h exp=%h/%h", cyc, rd_data1, rd_data2, exp_d1, exp_d2); end
      if (rd_valid1) begin
        n_chk++; if (rd_data1 !== cnt1 * 32'h01010101) begin n_fail++; $display("[TB] FAIL stream_word_l1 idx=%0d got=%h exp=%h", cnt1, rd_data1, cnt1 * 32'h01010101); end
        cnt1++;
      end
      if (rd_valid2) begin
        n_chk++; if (rd_data2 !== cnt2 * 32'h01010101) begin n_fail++; $display("[TB] FAIL stream_word_l2 idx=%0d got=%h exp=%h", cnt2, rd_data2, cnt2 * 32'h01010101); end
        cnt2++;
      end
      if (i == 128) begin
        n_chk++; if (cnt1 !== 64) begin n_fail++; $display("[TB] FAIL stream_no_bubble_l1 got=%0d exp=64", cnt1); end
      end
      if (i == 129) begin
        n_chk++; if (cnt2 !== 64) begin n_fail++; $display("[TB] FAIL stream_no_bubble_l2 got=%0d exp=64", cnt2); end
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] got1[$];
    logic [31:0] got2[$];
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: set_in(1'b1, 1'b1, 6'h3F, 32'hDEADBEEF, 4'hF);
        1: set_in(1'b1, 1'b0, 6'h3F, 32'h0, 4'h0);
        2: set_in(1'b1, 1'b1, 6'h3F, $urandom, 4'h0);
        3: set_in(1'b1, 1'b0, 6'h3F, 32'h0, 4'h0);
        4: set_in(1'b1, 1'b0, 6'h3F, 32'h0, 4'h0);
        5: set_in(1'b1, 1'b1, 6'h3F, 32'h12345678, 4'hF);
        9: set_in(1'b1, 1'b0, 6'h3F, 32'h0, 4'h0);
        default: set_in(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
      endcase
      step();
      if (rd_valid1) got1.push_back(rd_data1);
      if (rd_valid2) got2.push_back(rd_data2);
      n_chk++; if (rd_valid1 !== exp_v1 || rd_valid2 !== exp_v2) begin n_fail++; $display("[TB] FAIL wr_rd_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, rd_valid1, rd_valid2, exp_v1, exp_v2); end
      n_chk++; if (rd_data1 !== exp_d1 || rd_data2 !== exp_d2) begin n_fail++; $display("[TB] FAIL wr_rd_data cyc=%0d got=%h/%h exp=%h/%h", cyc, rd_data1, rd_data2, exp_d1, exp_d2); end
    end
    n_chk++; if (got1.size() !== 4 || got2.size() !== 4) begin n_fail++; $display("[TB] FAIL wr_rd_count got=%0d/%0d exp=4", got1.size(), got2.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        n_chk++; if (got1[k] !== 32'hDEADBEEF || got2[k] !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL wr_rd_word%0d got=%h/%h exp=deadbeef", k, got1[k], got2[k]); end
      end
      n_chk++; if (got1[3] !== 32'h12345678 || got2[3] !== 32'h12345678) begin n_fail++; $display("[TB] FAIL wr_rd_new got=%h/%h exp=12345678", got1[3], got2[3]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
             $urandom, 4'($urandom_range(0, 15)));
      step();
      n_chk++; if (rd_valid1 !== exp_v1 || rd_valid2 !== exp_v2) begin n_fail++; $display("[TB] FAIL random_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, rd_valid1, rd_valid2, exp_v1, exp_v2); end
      n_chk++; if (rd_data1 !== exp_d1 || rd_data2 !== exp_d2) begin n_fail++; $display("[TB] FAIL random_data cyc=%0d got=%h/%h exp=%h/%h", cyc, rd_data1, rd_data2, exp_d1, exp_d2); end
    end
  endtask

  task automatic test_reset_mid_clear();
    set_in(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
    step(); step();
    assert_reset();
    release_reset(2);
    for (int i = 0; i < 30; i++) begin
      step();
      n_chk++; if (ready1 !== 1'b0 || init_done2 !== 1'b0) begin n_fail++; $display("[TB] FAIL midclear_early_ready edge=%0d got=%b/%b exp=0", edges, ready1, init_done2); end
    end
    assert_reset();
    n_chk++; if (ready1 !== 1'b0 || ready2 !== 1'b0 || init_done1 !== 1'b0) begin n_fail++; $display("[TB] FAIL midclear_reset_outputs got=%b/%b/%b exp=0", ready1, ready2, init_done1); end
    release_reset(2);
    for (int i = 0; i < 64; i++) begin
      step();
      n_chk++; if (ready1 !== exp_ready || ready2 !== exp_ready || init_done1 !== exp_ready) begin n_fail++; $display("[TB] FAIL midclear_ready edge=%0d got=%b/%b/%b exp=%b", edges, ready1, ready2, init_done1, exp_ready); end
    end
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: set_in(1'b1, 1'b0, 6'h05, 32'h0, 4'h0);
        1: set_in(1'b1, 1'b0, 6'h3F, 32'h0, 4'h0);
        2: set_in(1'b1, 1'b0, 6'h03, 32'h0, 4'h0);
        default: set_in(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
      endcase
      step();
      n_chk++; if (rd_valid1 !== exp_v1 || rd_valid2 !== exp_v2) begin n_fail++; $display("[TB] FAIL midclear_rd_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, rd_valid1, rd_valid2, exp_v1, exp_v2); end
      n_chk++; if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin n_fail++; $display("[TB] FAIL midclear_zero cyc=%0d got=%h/%h exp=0", cyc, rd_data1, rd_data2); end
    end
  endtask

  task automatic test_reset_inflight();
    set_in(1'b1, 1'b1, 6'h07, 32'h55AA55AA, 4'hF);
    step();
    set_in(1'b1, 1'b0, 6'h07, 32'h0, 4'h0);
    step();
    set_in(1'b0, 1'b0, 6'h0, 32'h0, 4'h0);
    assert_reset();
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin n_fail++; $display("[TB] FAIL inflight_valid i=%0d got=%b/%b exp=0", i, rd_valid1, rd_valid2); end
      n_chk++; if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin n_fail++; $display("[TB] FAIL inflight_data i=%0d got=%h/%h exp=0", i, rd_data1, rd_data2); end
      @(posedge CLK);
      #1;
    end
    RSTn = 1'b1;
    for (int i = 0; i < 66; i++) begin
      step();
      n_chk++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin n_fail++; $display("[TB] FAIL inflight_late_valid cyc=%0d got=%b/%b exp=0", cyc, rd_valid1, rd_valid2); end
      n_chk++; if (ready2 !== exp_ready) begin n_fail++; $display("[TB] FAIL inflight_ready edge=%0d got=%b exp=%b", edges, ready2, exp_ready); end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; edges = 0; exp_ready = 1'b0;
    foreach (model[i]) model[i] = 32'h0;
    test_reset();
    test_strobe();
    test_stream();
    test_write_read();
    test_random();
    test_reset_mid_clear();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
